// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write front end.
// Optional readback verification is enabled with macro REGFILE_WR_VERIFY_EN.
package regfile_pkg;

   localparam int DEF_ADDR_W = 2;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 4;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wr_req_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      VERIFY = 2'd2
   } wr_state_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Synchronous request FIFO for the register-file writer.
// Pointers carry one extra bit so full and empty are distinguishable.
module regfile_wr_fifo
   import regfile_pkg::*;
#(
   parameter int  DEPTH = DEF_DEPTH,
   parameter type T     = wr_req_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_push,
   input  T     i_din,
   input  logic i_pop,
   input  logic i_flush,
   output T     o_head,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);

   T            r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_push;
   logic        w_pop;

   // A push into a full FIFO or a pop from an empty one is ignored.
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

   // Storage write; contents need no reset because the pointers gate validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_din;
      end
   end

   // Pointer update; flush discards everything queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/regfile_writer.sv
// Write-side front end for the 4x32 register file: queues (addr, data)
// requests and drains them into the wr/wa/wd port, one per WRITE cycle.
// Macro REGFILE_WR_VERIFY_EN adds a VERIFY cycle after each write that reads
// the register back through rb_addr/rb_data and sets a sticky err on mismatch.
module regfile_writer
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic              flush,
   output logic              wr,
   output logic [ADDR_W-1:0] wa,
   output logic [DATA_W-1:0] wd,
   output logic [ADDR_W-1:0] rb_addr,
   input  logic [DATA_W-1:0] rb_data,
   output logic              busy,
   output logic [7:0]        wr_count,
   output logic              err
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;

   req_t              w_push_req;
   req_t              w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_can_pop;
   logic              w_pop;

   wr_state_t         r_state;
   logic              r_wr;
   logic [ADDR_W-1:0] r_wa;
   logic [DATA_W-1:0] r_wd;
   logic [7:0]        r_wr_count;

   assign req_ready  = !w_full && !flush;
   assign w_push     = req_valid && req_ready;
   assign w_push_req = '{addr: req_addr, data: req_data};
   assign w_can_pop  = !w_empty && !flush;

`ifdef REGFILE_WR_VERIFY_EN
   logic r_err;
   // A WRITE is always followed by VERIFY, so only IDLE and VERIFY may pop.
   assign w_pop   = w_can_pop && (r_state != WRITE);
   assign rb_addr = (r_state == VERIFY) ? r_wa : '0;
   assign err     = r_err;
`else
   logic w_unused_rb;
   assign w_pop       = w_can_pop;
   assign rb_addr     = '0;
   assign err         = 1'b0;
   assign w_unused_rb = ^rb_data;
`endif

   assign wr       = r_wr;
   assign wa       = r_wa;
   assign wd       = r_wd;
   assign wr_count = r_wr_count;
   assign busy     = !w_empty || (r_state != IDLE);

   regfile_wr_fifo #(
      .DEPTH (DEPTH),
      .T     (req_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_din   (w_push_req),
      .i_pop   (w_pop),
      .i_flush (flush),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Writer FSM with registered write-port outputs, counter and error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_wr       <= 1'b0;
         r_wa       <= '0;
         r_wd       <= '0;
         r_wr_count <= '0;
`ifdef REGFILE_WR_VERIFY_EN
         r_err      <= 1'b0;
`endif
      end else begin
         r_wr <= 1'b0;
         if (w_pop) begin
            r_wr <= 1'b1;
            r_wa <= w_head.addr;
            r_wd <= w_head.data;
         end
         // The register file captures the write at the edge that ends WRITE.
         if (r_state == WRITE) begin
            r_wr_count <= r_wr_count + 8'd1;
         end
         case (r_state)
            IDLE: begin
               if (w_pop) r_state <= WRITE;
            end
            WRITE: begin
`ifdef REGFILE_WR_VERIFY_EN
               r_state <= VERIFY;
`else
               r_state <= w_pop ? WRITE : IDLE;
`endif
            end
`ifdef REGFILE_WR_VERIFY_EN
            VERIFY: begin
               if (rb_data != r_wd) r_err <= 1'b1;
               r_state <= w_pop ? WRITE : IDLE;
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_writer.sv
// Self-checking bench for regfile_writer with a behavioural 4x32 register file.
// Builds with or without REGFILE_WR_VERIFY_EN; expectations adapt to the macro.
module tb_regfile_writer;

`ifdef REGFILE_WR_VERIFY_EN
   localparam bit VERIFY_EN = 1'b1;
   localparam int SP        = 2;
`else
   localparam bit VERIFY_EN = 1'b0;
   localparam int SP        = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [1:0]  req_addr = '0;
   logic [31:0] req_data = '0;
   logic        flush = 1'b0;
   logic        force_zero = 1'b0;
   logic        req_ready;
   logic        wr;
   logic [1:0]  wa;
   logic [31:0] wd;
   logic [1:0]  rb_addr;
   logic [31:0] rb_data;
   logic        busy;
   logic [7:0]  wr_count;
   logic        err;

   logic [31:0] regs [4] = '{default: 32'h0};
   int          cyc = 0;
   logic [1:0]  log_a [$];
   logic [31:0] log_d [$];
   int          log_c [$];
   int          pass_cnt = 0;
   int          total = 0;

   always #5 clk = ~clk;

   // Behavioural register file read port (rs1 -> read1).
   assign rb_data = force_zero ? 32'h0 : regs[rb_addr];

   regfile_writer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .flush     (flush),
      .wr        (wr),
      .wa        (wa),
      .wd        (wd),
      .rb_addr   (rb_addr),
      .rb_data   (rb_data),
      .busy      (busy),
      .wr_count  (wr_count),
      .err       (err)
   );

   // Register file write port plus a log of every write seen on it.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wr) begin
         regs[wa] <= wd;
         log_a.push_back(wa);
         log_d.push_back(wd);
         log_c.push_back(cyc);
         $display("write  cyc=%0d wa=%0d wd=%08h", cyc, wa, wd);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
      log_c.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 1'b0;
      flush = 1'b0;
      force_zero = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_log();
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic push(input logic [1:0] a, input logic [31:0] d, output bit waited);
      int n = 0;
      waited = 1'b0;
      req_addr = a;
      req_data = d;
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         waited = 1'b1;
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         $display("FAIL push_timeout req_ready=%b required 1", req_ready);
      end
      $display("push   addr=%0d data=%08h", a, d);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         total++;
         $display("FAIL idle_timeout busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++; if (wr !== 1'b0) $display("FAIL reset_wr got %b required 0", wr); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b required 0", busy); else pass_cnt++;
      total++; if (wr_count !== 8'd0) $display("FAIL reset_wr_count got %0d required 0", wr_count); else pass_cnt++;
      total++; if (err !== 1'b0) $display("FAIL reset_err got %b required 0", err); else pass_cnt++;
      total++;
      if ({wa, wd, rb_addr} !== 36'h0) $display("FAIL reset_addr_data got wa=%0d wd=%08h rb=%0d required 0", wa, wd, rb_addr);
      else pass_cnt++;
      do_reset();
   endtask

   task automatic test_single_write();
      bit w;
      do_reset();
      push(2'd2, 32'hDEAD_BEEF, w);
      total++; if (wr !== 1'b0) $display("FAIL single_latency wr got %b required 0", wr); else pass_cnt++;
      @(negedge clk);
      total++;
      if (wr !== 1'b1 || wa !== 2'd2 || wd !== 32'hDEAD_BEEF)
         $display("FAIL single_write got wr=%b wa=%0d wd=%08h required 1/2/deadbeef", wr, wa, wd);
      else pass_cnt++;
      @(negedge clk);
      total++;
      if (rb_addr !== (VERIFY_EN ? 2'd2 : 2'd0) || busy !== VERIFY_EN || wr !== 1'b0)
         $display("FAIL single_after got rb_addr=%0d busy=%b wr=%b required %0d/%b/0", rb_addr, busy, wr,
                  VERIFY_EN ? 2 : 0, VERIFY_EN);
      else pass_cnt++;
      wait_idle();
      total++; if (regs[2] !== 32'hDEAD_BEEF) $display("FAIL single_readback got %08h required deadbeef", regs[2]); else pass_cnt++;
      total++; if (wr_count !== 8'd1) $display("FAIL single_wr_count got %0d required 1", wr_count); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bit w;
      bit any_wait = 1'b0;
      int bad = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         push(2'(i % 4), 32'h11 * (i + 1), w);
         any_wait |= w;
      end
      wait_idle();
      total++;
      if (any_wait !== VERIFY_EN) $display("FAIL b2b_backpressure got %b required %b", any_wait, VERIFY_EN);
      else pass_cnt++;
      if (log_a.size() == 8) begin
         for (int i = 0; i < 8; i++)
            if (log_a[i] !== 2'(i % 4) || log_d[i] !== 32'h11 * (i + 1)) bad++;
      end
      total++;
      if (log_a.size() != 8 || bad != 0) $display("FAIL b2b_order got %0d writes %0d wrong required 8/0", log_a.size(), bad);
      else pass_cnt++;
      total++;
      if (log_c.size() != 8 || (log_c[7] - log_c[0]) != 7 * SP)
         $display("FAIL b2b_throughput got span %0d required %0d", log_c.size() == 8 ? log_c[7] - log_c[0] : -1, 7 * SP);
      else pass_cnt++;
      total++; if (wr_count !== 8'd8) $display("FAIL b2b_wr_count got %0d required 8", wr_count); else pass_cnt++;
      bad = 0;
      for (int a = 0; a < 4; a++) if (regs[a] !== 32'h11 * (a + 5)) bad++;
      total++; if (bad != 0) $display("FAIL b2b_last_wins got %0d wrong regs required 0", bad); else pass_cnt++;
   endtask

   task automatic test_flush();
      bit w;
      do_reset();
      push(2'd0, 32'h0000_000A, w);
      push(2'd1, 32'h0000_000B, w);
      total++; if (wr !== 1'b1 || wa !== 2'd0) $display("FAIL flush_first_write got wr=%b wa=%0d required 1/0", wr, wa); else pass_cnt++;
      flush = 1'b1;
      req_valid = 1'b1;
      req_addr = 2'd3;
      req_data = 32'h0000_000C;
      #1;
      total++; if (req_ready !== 1'b0) $display("FAIL flush_ready got %b required 0", req_ready); else pass_cnt++;
      @(negedge clk);
      flush = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0 || wr !== 1'b0) $display("FAIL flush_busy got busy=%b wr=%b required 0/0", busy, wr); else pass_cnt++;
      repeat (4) @(negedge clk);
      total++;
      if (log_d.size() != 1 || log_d[0] !== 32'h0000_000A)
         $display("FAIL flush_writes got %0d writes required 1 (data 0000000a)", log_d.size());
      else pass_cnt++;
      total++; if (wr_count !== 8'd1) $display("FAIL flush_wr_count got %0d required 1", wr_count); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      bit w;
      int n = 0;
      do_reset();
      push(2'd0, 32'h0000_0010, w);
      push(2'd1, 32'h0000_0020, w);
      push(2'd2, 32'h0000_0030, w);
      while (!wr && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++; if (wr !== 1'b1) $display("FAIL arst_precondition wr got %b required 1", wr); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (wr !== 1'b0 || busy !== 1'b0 || wr_count !== 8'd0)
         $display("FAIL arst_immediate got wr=%b busy=%b wr_count=%0d required 0/0/0", wr, busy, wr_count);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      repeat (5) @(negedge clk);
      total++; if (log_a.size() != 0 || wr !== 1'b0) $display("FAIL arst_no_write got %0d writes required 0", log_a.size()); else pass_cnt++;
      push(2'd3, 32'h0000_0077, w);
      wait_idle();
      total++;
      if (log_a.size() != 1 || log_a[0] !== 2'd3 || log_d[0] !== 32'h0000_0077)
         $display("FAIL arst_new_push got %0d writes required 1 to reg 3", log_a.size());
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      bit w;
      int bad = 0;
      do_reset();
      for (int i = 0; i < 256; i++) push(2'(i % 4), 32'h1000_0000 + i, w);
      wait_idle();
      if (log_a.size() == 256) begin
         for (int i = 0; i < 256; i++)
            if (log_a[i] !== 2'(i % 4) || log_d[i] !== 32'h1000_0000 + i) bad++;
      end
      total++;
      if (log_a.size() != 256 || bad != 0) $display("FAIL wrap_order got %0d writes %0d wrong required 256/0", log_a.size(), bad);
      else pass_cnt++;
      total++; if (wr_count !== 8'd0) $display("FAIL wrap_wr_count got %0d required 0", wr_count); else pass_cnt++;
      bad = 0;
      for (int a = 0; a < 4; a++) if (regs[a] !== 32'h1000_0000 + 252 + a) bad++;
      total++; if (bad != 0) $display("FAIL wrap_regs got %0d wrong regs required 0", bad); else pass_cnt++;
   endtask

   task automatic test_verify();
      bit w;
      do_reset();
      for (int i = 0; i < 10; i++) push(2'(i % 4), 32'h100 + i, w);
      wait_idle();
      total++; if (err !== 1'b0) $display("FAIL verify_clean_err got %b required 0", err); else pass_cnt++;
      total++;
      if (log_c.size() != 10 || (log_c[9] - log_c[0]) != 9 * SP)
         $display("FAIL verify_spacing got span %0d required %0d", log_c.size() == 10 ? log_c[9] - log_c[0] : -1, 9 * SP);
      else pass_cnt++;
      force_zero = 1'b1;
      push(2'd1, 32'h0000_0005, w);
      wait_idle();
      force_zero = 1'b0;
      total++; if (err !== VERIFY_EN) $display("FAIL verify_err_set got %b required %b", err, VERIFY_EN); else pass_cnt++;
      push(2'd2, 32'h0000_0006, w);
      wait_idle();
      total++; if (err !== VERIFY_EN) $display("FAIL verify_err_sticky got %b required %b", err, VERIFY_EN); else pass_cnt++;
      total++; if (rb_addr !== 2'd0) $display("FAIL verify_rb_idle got %0d required 0", rb_addr); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_wrap();
      test_verify();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
